// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder; the requester drives the
// operands and start, the adder drives status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop walks
// the operands LSB first, one bit per clock, and publishes the word on completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic             r_carry;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_cn;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Returns {carry_out, sum} of a single full-adder slice.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign {w_cn, w_s} = full_add(r_a[0], r_b[0], r_c);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_res_next  = {w_s, r_res[WIDTH-1:1]};

  // busy/done trail the state by one cycle, so the DONE state can already
  // accept the next start while done is presented on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (r_state == RUN);
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_c     <= bus.sub ? ~bus.cin : bus.cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_res <= w_res_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cn;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // r_c is still the carry into the MSB here
            r_sum   <= w_res_next;
            r_carry <= w_cn;
            r_ovf   <= r_c ^ w_cn;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sum      = r_sum;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder at WIDTH=8 and WIDTH=4,
// scored against an integer-arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) i8 ();
  serial_adder_if #(.WIDTH(4)) i4 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(i8.slave));
  serial_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(i4.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int w, input int a, input int b, input bit ci, input bit sb,
                                output int s, output bit c, output bit v);
    int m;
    int r;
    int sa;
    int sbv;
    int rs;
    m = 1 << w;
    if (!sb) begin
      r = a + b + int'(ci);
      c = (r >= m);
    end else begin
      r = a - b - int'(ci);
      c = (a >= b + int'(ci));
    end
    s   = r & (m - 1);
    sa  = (a >= m / 2) ? a - m : a;
    sbv = (b >= m / 2) ? b - m : b;
    rs  = sb ? sa - sbv - int'(ci) : sa + sbv + int'(ci);
    v   = (rs < -(m / 2)) || (rs >= m / 2);
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                     input string tag);
    int s;
    bit c;
    bit v;
    int nb;
    int nd;
    int dk;
    int both;
    logic [7:0] gs;
    logic gc;
    logic gv;
    model(8, int'(a), int'(b), ci, sb, s, c, v);
    @(negedge clk);
    i8.a = a; i8.b = b; i8.cin = ci; i8.sub = sb; i8.start = 1'b1;
    @(posedge clk); #1;
    i8.start = 1'b0;
    nb = 0; nd = 0; dk = 0; both = 0; gs = '0; gc = 1'b0; gv = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (i8.busy) nb++;
      if (i8.busy && i8.done) both++;
      if (i8.done) begin
        nd++; dk = k; gs = i8.sum; gc = i8.carry; gv = i8.overflow;
      end
    end
    check($sformatf("%s.sum", tag), 64'(gs), 64'(s));
    check($sformatf("%s.carry", tag), 64'(gc), 64'(c));
    check($sformatf("%s.ovf", tag), 64'(gv), 64'(v));
    check($sformatf("%s.done_cycle", tag), 64'(dk), 64'd9);
    check($sformatf("%s.busy_cycles", tag), 64'(nb), 64'd8);
    check($sformatf("%s.done_count", tag), 64'(nd), 64'd1);
    check($sformatf("%s.busy_and_done", tag), 64'(both), 64'd0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sb);
    int s;
    bit c;
    bit v;
    int nb;
    int dk;
    logic [3:0] gs;
    logic gc;
    logic gv;
    model(4, int'(a), int'(b), ci, sb, s, c, v);
    @(negedge clk);
    i4.a = a; i4.b = b; i4.cin = ci; i4.sub = sb; i4.start = 1'b1;
    @(posedge clk); #1;
    i4.start = 1'b0;
    nb = 0; dk = 0; gs = '0; gc = 1'b0; gv = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (i4.busy) nb++;
      if (i4.done) begin
        dk = k; gs = i4.sum; gc = i4.carry; gv = i4.overflow;
      end
    end
    check($sformatf("w4 %h%s%h c%0d sum", a, sb ? "-" : "+", b, ci), 64'(gs), 64'(s));
    check($sformatf("w4 %h%s%h c%0d carry", a, sb ? "-" : "+", b, ci), 64'(gc), 64'(c));
    check($sformatf("w4 %h%s%h c%0d ovf", a, sb ? "-" : "+", b, ci), 64'(gv), 64'(v));
    check($sformatf("w4 %h%s%h c%0d lat", a, sb ? "-" : "+", b, ci), 64'(dk), 64'd5);
    check($sformatf("w4 %h%s%h c%0d busy", a, sb ? "-" : "+", b, ci), 64'(nb), 64'd4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    int d1;
    int d2;
    logic [7:0] s1;
    logic [7:0] s2;
    int ex_s;
    bit ex_c;
    bit ex_v;

    rst = 1'b1;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0; i8.sub = 1'b0;
    i4.start = 1'b0; i4.a = '0; i4.b = '0; i4.cin = 1'b0; i4.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 64'(i8.busy), 64'd0);
    check("rst.done", 64'(i8.done), 64'd0);
    check("rst.sum", 64'(i8.sum), 64'd0);
    check("rst.carry", 64'(i8.carry), 64'd0);
    check("rst.ovf", 64'(i8.overflow), 64'd0);
    check("rst4.sum", 64'(i4.sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic cases
    op8(8'h3C, 8'h0F, 1'b0, 1'b0, "add_3c_0f");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    op8(8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01");
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c");
    op8(8'h05, 8'h07, 1'b0, 1'b1, "sub_05_07");
    op8(8'h80, 8'h01, 1'b0, 1'b1, "sub_80_01");
    op8(8'h10, 8'h00, 1'b1, 1'b1, "sub_10_00_b");

    // Start during RUN must be dropped
    @(negedge clk);
    i8.a = 8'h01; i8.b = 8'h02; i8.cin = 1'b0; i8.sub = 1'b0; i8.start = 1'b1;
    @(posedge clk); #1;
    i8.start = 1'b0;
    nd = 0; d1 = 0; s1 = '0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (i8.done) begin nd++; d1 = k; s1 = i8.sum; end
      if (k == 3) begin
        i8.a = 8'hAA; i8.b = 8'h55; i8.start = 1'b1;
      end
      if (k == 4) i8.start = 1'b0;
    end
    check("drop.sum", 64'(s1), 64'h03);
    check("drop.done_count", 64'(nd), 64'd1);
    check("drop.done_cycle", 64'(d1), 64'd9);

    // Reset in the 4th RUN cycle discards the operation
    @(negedge clk);
    i8.a = 8'hF0; i8.b = 8'h0E; i8.cin = 1'b1; i8.sub = 1'b0; i8.start = 1'b1;
    @(posedge clk); #1;
    i8.start = 1'b0;
    for (int k = 1; k <= 3; k++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.busy", 64'(i8.busy), 64'd0);
    check("midrst.done", 64'(i8.done), 64'd0);
    check("midrst.sum", 64'(i8.sum), 64'd0);
    check("midrst.carry", 64'(i8.carry), 64'd0);
    check("midrst.ovf", 64'(i8.overflow), 64'd0);
    nd = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (i8.done || i8.busy) nd++;
    end
    check("midrst.no_activity", 64'(nd), 64'd0);
    op8(8'h20, 8'h22, 1'b0, 1'b0, "after_rst");

    // Back-to-back with start held through DONE
    @(negedge clk);
    i8.a = 8'h11; i8.b = 8'h22; i8.cin = 1'b0; i8.sub = 1'b0; i8.start = 1'b1;
    @(posedge clk); #1;
    i8.a = 8'h90; i8.b = 8'h33; i8.sub = 1'b1;
    nd = 0; d1 = 0; d2 = 0; s1 = '0; s2 = '0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (i8.done) begin
        nd++;
        if (nd == 1) begin d1 = k; s1 = i8.sum; end
        else begin d2 = k; s2 = i8.sum; end
      end
      if (k == 9) i8.start = 1'b0;
      if (k == 10) check("b2b.busy_after_restart", 64'(i8.busy), 64'd1);
    end
    model(8, 'h90, 'h33, 1'b0, 1'b1, ex_s, ex_c, ex_v);
    check("b2b.done_count", 64'(nd), 64'd2);
    check("b2b.first_done", 64'(d1), 64'd9);
    check("b2b.period", 64'(d2 - d1), 64'd9);
    check("b2b.sum1", 64'(s1), 64'h33);
    check("b2b.sum2", 64'(s2), 64'(ex_s));

    // Randomized WIDTH=8 operations
    for (int n = 0; n < 40; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
    end

    // Exhaustive WIDTH=4
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int m = 0; m < 4; m++)
          op4(4'(a), 4'(b), m[0], m[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
